// File: rtl/mips_pkg.sv
// Shared definitions for the EXE-stage forwarding / load-use hazard logic:
// register address width, operand-select codes and the shadow-slot layouts.
package mips_pkg;

    // 32 architectural registers; register 0 reads as zero and is never a real producer.
    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] SEL_REG  = 2'd0;
    localparam logic [1:0] SEL_MEM  = 2'd1;
    localparam logic [1:0] SEL_WB   = 2'd2;
    localparam logic [1:0] SEL_RSVD = 2'd3;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] src1;
        logic [REG_ADDR_W-1:0] src2;
        logic                  two_src;
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb_en;
        logic                  mem_read;
    } exe_slot_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb_en;
        logic                  mem_read;
    } mem_slot_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb_en;
    } wb_slot_t;

    localparam exe_slot_t EXE_BUBBLE = '0;

    // True when an instruction reading src1 (and src2 if two_src) depends on a nonzero dest.
    function automatic logic reads_reg(input logic [REG_ADDR_W-1:0] dest,
                                       input logic [REG_ADDR_W-1:0] src1,
                                       input logic [REG_ADDR_W-1:0] src2,
                                       input logic                  two_src);
        return (dest != '0) && ((dest == src1) || (two_src && (dest == src2)));
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority forwarding comparator for one EXE operand: the youngest producer
// (MEM) wins over WB, and register 0 is never forwarded.
module fwd_select
    import mips_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic                  src_used_i,
    input  logic [REG_ADDR_W-1:0] mem_dest_i,
    input  logic                  mem_wb_en_i,
    input  logic [REG_ADDR_W-1:0] wb_dest_i,
    input  logic                  wb_wb_en_i,
    output logic [1:0]            sel_o
);

    always_comb begin
        sel_o = SEL_REG;
        if (src_used_i && (src_i != '0)) begin
            if (mem_wb_en_i && (mem_dest_i == src_i)) begin
                sel_o = SEL_MEM;
            end else if (wb_wb_en_i && (wb_dest_i == src_i)) begin
                sel_o = SEL_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EXE operand-select and load-use stall generator with EXE/MEM/WB shadow slots.
// Build with FWD_HAZARD_FORWARDING_EN for bypassing; without it, dependents stall until WB.
module fwd_hazard_unit
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_mem_read,
    output logic [1:0]            src1_decider,
    output logic [1:0]            src2_decider,
    output logic                  hazard_stall
);

    exe_slot_t exe_q, exe_d;
    mem_slot_t mem_q, mem_d;
    wb_slot_t  wb_q,  wb_d;
    logic      stall_raw;

    always_comb begin
        exe_d = exe_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!freeze) begin
            wb_d  = '{dest: mem_q.dest, wb_en: mem_q.wb_en};
            mem_d = '{dest: exe_q.dest, wb_en: exe_q.wb_en, mem_read: exe_q.mem_read};
            // A flushed, stalled or empty ID slot enters EXE as a bubble.
            if (flush || hazard_stall || !id_valid) begin
                exe_d = EXE_BUBBLE;
            end else begin
                exe_d = '{src1:     id_src1,
                          src2:     id_src2,
                          two_src:  id_two_src,
                          dest:     id_dest,
                          wb_en:    id_wb_en,
                          mem_read: id_mem_read};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_q <= EXE_BUBBLE;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            exe_q <= exe_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

`ifdef FWD_HAZARD_FORWARDING_EN
    fwd_select u_sel_src1 (
        .src_i       (exe_q.src1),
        .src_used_i  (1'b1),
        .mem_dest_i  (mem_q.dest),
        .mem_wb_en_i (mem_q.wb_en),
        .wb_dest_i   (wb_q.dest),
        .wb_wb_en_i  (wb_q.wb_en),
        .sel_o       (src1_decider)
    );

    fwd_select u_sel_src2 (
        .src_i       (exe_q.src2),
        .src_used_i  (exe_q.two_src),
        .mem_dest_i  (mem_q.dest),
        .mem_wb_en_i (mem_q.wb_en),
        .wb_dest_i   (wb_q.dest),
        .wb_wb_en_i  (wb_q.wb_en),
        .sel_o       (src2_decider)
    );

    // Only a load in EXE cannot be bypassed in time; everything else forwards.
    assign stall_raw = id_valid && exe_q.mem_read
                    && reads_reg(exe_q.dest, id_src1, id_src2, id_two_src);

    logic unused_slot_bits;
    assign unused_slot_bits = mem_q.mem_read;
`else
    assign src1_decider = SEL_REG;
    assign src2_decider = SEL_REG;

    // No bypass network: wait until the producer has left MEM (WB writes first half-cycle).
    assign stall_raw = id_valid
                    && ((exe_q.wb_en && reads_reg(exe_q.dest, id_src1, id_src2, id_two_src))
                     || (mem_q.wb_en && reads_reg(mem_q.dest, id_src1, id_src2, id_two_src)));

    logic unused_slot_bits;
    assign unused_slot_bits = ^{exe_q.src1, exe_q.src2, exe_q.two_src, mem_q.mem_read, wb_q};
`endif

    assign hazard_stall = stall_raw && !freeze;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed, table-driven bench for fwd_hazard_unit; expectations follow the
// build mode selected by FWD_HAZARD_FORWARDING_EN.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       freeze, flush, id_valid, id_two_src, id_wb_en, id_mem_read;
    logic [4:0] id_src1, id_src2, id_dest;
    logic [1:0] src1_decider, src2_decider;
    logic       hazard_stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .id_dest      (id_dest),
        .id_wb_en     (id_wb_en),
        .id_mem_read  (id_mem_read),
        .src1_decider (src1_decider),
        .src2_decider (src2_decider),
        .hazard_stall (hazard_stall)
    );

    typedef struct {
        logic       v;
        logic [4:0] s1, s2;
        logic       two;
        logic [4:0] d;
        logic       we, mr, fl, fz;
        logic [1:0] e1, e2;
        logic       st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int v, s1, s2, two, d, we, mr, fl, fz, e1, e2, st);
        vec_t r;
        r.v  = v[0];   r.s1 = s1[4:0]; r.s2 = s2[4:0]; r.two = two[0];
        r.d  = d[4:0]; r.we = we[0];   r.mr = mr[0];
        r.fl = fl[0];  r.fz = fz[0];
        r.e1 = e1[1:0]; r.e2 = e2[1:0]; r.st = st[0];
        return r;
    endfunction

    task automatic apply(input vec_t t);
        id_valid = t.v;  id_src1 = t.s1; id_src2 = t.s2; id_two_src = t.two;
        id_dest  = t.d;  id_wb_en = t.we; id_mem_read = t.mr;
        flush    = t.fl; freeze = t.fz;
    endtask

    task automatic chk(input string name, input int row, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%0d want=%0d", name, row, act, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        apply(mk(1, 3, 3, 1, 3, 1, 1, 0, 0, 0, 0, 0));
        #1;
        chk("rst_src1", -1, src1_decider, 2'd0);
        chk("rst_src2", -1, src2_decider, 2'd0);
        chk("rst_stall", -1, {1'b0, hazard_stall}, 2'd0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // fields: v s1 s2 two d we mr flush freeze | exp src1 src2 stall
`ifdef FWD_HAZARD_FORWARDING_EN
        vecs.push_back(mk(1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0));  // add r3,r1,r2
        vecs.push_back(mk(1, 3, 5, 1, 4, 1, 0, 0, 0, 0, 0, 0));  // sub r4,r3,r5
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));  // sub in EXE: MEM fwd
        vecs.push_back(mk(1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0));  // add r3
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // nop
        vecs.push_back(mk(1, 7, 3, 1, 6, 1, 0, 0, 0, 0, 0, 0));  // or r6,r7,r3
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));  // or in EXE: WB fwd
        vecs.push_back(mk(1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0));  // add r3
        vecs.push_back(mk(1, 4, 5, 1, 3, 1, 0, 0, 0, 0, 0, 0));  // add r3 again
        vecs.push_back(mk(1, 3, 3, 1, 10, 1, 0, 0, 0, 0, 0, 0)); // sub r10,r3,r3
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));  // MEM beats WB
        vecs.push_back(mk(1, 2, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0));  // lw r8
        vecs.push_back(mk(1, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0, 1));  // add r9,r8,r1: stall
        vecs.push_back(mk(1, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0));  // held, bubble in EXE
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));  // add in EXE: WB fwd
        vecs.push_back(mk(1, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0));  // add r0
        vecs.push_back(mk(1, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0));  // sub r4,r0,r0
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // r0 never forwarded
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));  // lw r0
        vecs.push_back(mk(1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0));  // consumer of r0: no stall
        vecs.push_back(mk(1, 1, 2, 1, 7, 1, 0, 1, 0, 0, 0, 0));  // add r7, flushed
        vecs.push_back(mk(1, 7, 7, 1, 11, 1, 0, 0, 0, 0, 0, 0)); // sub r11,r7,r7
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // no fwd from flushed
        vecs.push_back(mk(1, 1, 0, 0, 12, 1, 1, 0, 0, 0, 0, 0)); // lw r12
        vecs.push_back(mk(1, 12, 1, 1, 13, 1, 0, 1, 0, 0, 0, 1));// use + flush together
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // bubble only
        vecs.push_back(mk(1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0));  // add r3
        vecs.push_back(mk(1, 3, 5, 1, 4, 1, 0, 0, 0, 0, 0, 0));  // sub r4,r3,r5
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));  // freeze 1
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));  // freeze 2
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));  // freeze 3
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));  // released
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0));  // lw r8
        vecs.push_back(mk(1, 8, 1, 1, 9, 1, 0, 0, 1, 0, 0, 0));  // stall gated by freeze
        vecs.push_back(mk(1, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0, 1));  // stall after freeze
        vecs.push_back(mk(1, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0));  // add r3
        vecs.push_back(mk(1, 4, 3, 0, 5, 1, 0, 0, 0, 0, 0, 0));  // addi: src2 unused
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // src2 forced to 0
        vecs.push_back(mk(1, 1, 0, 0, 14, 1, 1, 0, 0, 0, 0, 0)); // lw r14
        vecs.push_back(mk(1, 2, 14, 0, 6, 1, 0, 0, 0, 0, 0, 0)); // src2 unused: no stall
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 15, 1, 1, 0, 0, 0, 0, 0)); // lw r15
        vecs.push_back(mk(1, 2, 15, 1, 0, 0, 0, 0, 0, 0, 0, 1)); // sw via src2: stall
        vecs.push_back(mk(1, 2, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));  // sw in EXE: WB fwd src2
`else
        vecs.push_back(mk(1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0));  // add r3,r1,r2
        vecs.push_back(mk(1, 3, 5, 1, 4, 1, 0, 0, 0, 0, 0, 1));  // sub: producer in EXE
        vecs.push_back(mk(1, 3, 5, 1, 4, 1, 0, 0, 0, 0, 0, 1));  // producer in MEM
        vecs.push_back(mk(1, 3, 5, 1, 4, 1, 0, 0, 0, 0, 0, 0));  // producer in WB: go
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0));  // lw r8
        vecs.push_back(mk(1, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0, 1));  // add r9,r8,r1
        vecs.push_back(mk(1, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0));  // add r0
        vecs.push_back(mk(1, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0));  // consumer of r0: no stall
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0));  // add r3
        vecs.push_back(mk(1, 4, 3, 0, 5, 1, 0, 0, 0, 0, 0, 0));  // src2 unused, r4 only in WB
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2, 1, 7, 1, 0, 1, 0, 0, 0, 0));  // add r7, flushed
        vecs.push_back(mk(1, 7, 7, 1, 11, 1, 0, 0, 0, 0, 0, 0)); // no stall on flushed
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 12, 1, 1, 0, 0, 0, 0, 0)); // lw r12
        vecs.push_back(mk(1, 12, 1, 1, 13, 1, 0, 1, 0, 0, 0, 1));// use + flush together
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0));  // add r3
        vecs.push_back(mk(1, 3, 5, 1, 4, 1, 0, 0, 1, 0, 0, 0));  // stall gated by freeze
        vecs.push_back(mk(1, 3, 5, 1, 4, 1, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3, 5, 1, 4, 1, 0, 0, 0, 0, 0, 1));  // released
        vecs.push_back(mk(1, 3, 5, 1, 4, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 3, 5, 1, 4, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1));  // sw: src2 hits MEM r4
        vecs.push_back(mk(1, 2, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            @(negedge clk);
            chk("src1_decider", i, src1_decider, vecs[i].e1);
            chk("src2_decider", i, src2_decider, vecs[i].e2);
            chk("hazard_stall", i, {1'b0, hazard_stall}, {1'b0, vecs[i].st});
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of a load-use stall.
        apply(mk(1, 1, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        apply(mk(1, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("pre_rst_stall", -2, {1'b0, hazard_stall}, 2'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_src1", -2, src1_decider, 2'd0);
        chk("mid_rst_src2", -2, src2_decider, 2'd0);
        chk("mid_rst_stall", -2, {1'b0, hazard_stall}, 2'd0);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_stall", -2, {1'b0, hazard_stall}, 2'd0);
        chk("post_rst_src1", -2, src1_decider, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Producer side of the EXE-stage operand-select interface.
- Tracks destination/write-enable of instructions in EXE, MEM, WB via internal shadow pipeline registers.
- Drives the 2-bit src1/src2 select codes consumed by the EXE operand muxes, and the load-use stall/bubble control to IF/ID.
- Sits beside the ID/EXE/MEM/WB pipeline registers and advances in lockstep with them.

Parameters:
- REG_ADDR_W, 5, register-file address width (32 registers; register 0 hard-wired zero).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  global pipeline hold (memory wait); all shadow state holds.
- flush  in  1  taken branch; instruction entering EXE is squashed.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  REG_ADDR_W  ID source register 1.
- id_src2  in  REG_ADDR_W  ID source register 2.
- id_two_src  in  1  ID instruction reads src2 (R-type, store, branch).
- id_dest  in  REG_ADDR_W  ID destination register.
- id_wb_en  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- src1_decider  out  2  EXE operand-1 select.
- src2_decider  out  2  EXE operand-2 select.
- hazard_stall  out  1  hold PC and IF/ID; ID/EXE loads a bubble.

Behaviour:
- Select encoding: 0 = ID/EXE register value, 1 = MEM-stage ALU result, 2 = WB-stage result, 3 = reserved, never driven.
- Shadow registers:
  - EXE slot: src1, src2, two_src, dest, wb_en, mem_read.
  - MEM slot: dest, wb_en, mem_read.
  - WB slot: dest, wb_en.
- Reset (rst low, asynchronous): all slots cleared, wb_en=0 and mem_read=0. Outputs are then src1_decider=0, src2_decider=0, hazard_stall=0.
- Clock edge, freeze=1: every slot holds.
- Clock edge, freeze=0:
  - WB slot <- MEM slot.
  - MEM slot <- EXE slot.
  - EXE slot <- ID inputs, or a bubble (wb_en=0, mem_read=0, two_src=0) when any of these holds: hazard_stall=1, flush=1, or id_valid=0.
- flush and hazard_stall together: a bubble is inserted; flush wins, and the stall is irrelevant.
- Decider logic (combinational from the EXE slot; zero cycles from slot to output):
  - src1_decider=1 if mem.wb_en and mem.dest==exe.src1 and exe.src1!=0.
  - Otherwise src1_decider=2 if wb.wb_en and wb.dest==exe.src1 and exe.src1!=0.
  - Otherwise src1_decider=0.
  - MEM has priority over WB.
  - src2_decider follows the same rules using exe.src2, and is forced to 0 when exe.two_src=0.
- hazard_stall (combinational from ID inputs and the EXE slot):
  - Asserts when id_valid, exe.mem_read, exe.dest!=0, and (exe.dest==id_src1 or (id_two_src and exe.dest==id_src2)).
  - Exactly one stall cycle per load-use pair. After the bubble, the load is in MEM and its data arrives via WB forwarding (select 2) one cycle later in EXE.
- hazard_stall is gated low while freeze=1.
- The register file writes in the first half-cycle, so no hazard is checked against the WB slot at ID.

Optional Feature:
- Macro: FWD_HAZARD_FORWARDING_EN.
- Defined: behaviour as above.
- Undefined:
  - src1_decider and src2_decider are tied to 0.
  - hazard_stall asserts when an ID source (src2 only if id_two_src) equals a nonzero dest of the EXE slot or MEM slot with wb_en=1, regardless of mem_read.
  - Dependent instructions stall until the producer reaches WB.

Decomposition:
- Shared package (mips_pkg):
  - REG_ADDR_W.
  - Localparams SEL_REG=2'd0, SEL_MEM=2'd1, SEL_WB=2'd2, SEL_RSVD=2'd3.
  - Bubble-slot constant.
- One natural sub-module: fwd_select, the combinational priority comparator for a single operand. It is instantiated twice.

Test Plan:
- add r3,r1,r2 then sub r4,r3,r5 back-to-back -> when sub is in EXE: src1_decider=1, src2_decider=0, hazard_stall=0 throughout.
- add r3 then nop then or r6,r7,r3 -> when or is in EXE: src2_decider=2.
- add r3 and add r3 in both MEM and WB with a consumer of r3 -> decider=1 (MEM priority).
- lw r8 then add r9,r8,r1 -> hazard_stall=1 for exactly one cycle, bubble enters EXE, then src1_decider=2 when add is in EXE.
- Writer dest r0 followed by a consumer of r0 -> deciders stay 0, no stall.
- Combined control:
  - freeze=1 for 3 cycles mid-dependency -> deciders unchanged across the freeze.
  - flush=1 -> the next EXE slot is a bubble, with no forwarding from it two cycles later.
  - rst low mid-stream -> outputs immediately 0.
